// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared state encodings, output modes and saturation bounds for acc_array
package acc_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   localparam logic OUT_MODE_RAW = 1'b0;
   localparam logic OUT_MODE_Q   = 1'b1;

   // Two's-complement limits of a w-bit value, 64 bits wide so callers slice what they need.
   function automatic logic [63:0] pos_bound(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] neg_bound(input int w);
      return ~pos_bound(w);
   endfunction

endpackage

// File: rtl/acc_sat_lane.sv
// rtl/acc_sat_lane.sv - one saturating accumulator lane with sticky saturation flag
module acc_sat_lane
   import acc_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              zero,
   input  logic              load,
   input  logic [ACC_W-1:0]  load_val,
   input  logic              add,
   input  logic [DATA_W-1:0] data,
   output logic [ACC_W-1:0]  value,
   output logic              sat
);

   localparam logic [63:0]      MAX64    = pos_bound(ACC_W);
   localparam logic [63:0]      MIN64    = neg_bound(ACC_W);
   localparam logic [ACC_W-1:0] LANE_MAX = MAX64[ACC_W-1:0];
   localparam logic [ACC_W-1:0] LANE_MIN = MIN64[ACC_W-1:0];

   logic [ACC_W:0]   sum;
   logic             ovf;
   logic [ACC_W-1:0] sum_sat;

   // One guard bit: overflow shows up as the two top bits disagreeing.
   assign sum     = {value[ACC_W-1], value} + {{(ACC_W + 1 - DATA_W){data[DATA_W-1]}}, data};
   assign ovf     = sum[ACC_W] ^ sum[ACC_W-1];
   assign sum_sat = !ovf ? sum[ACC_W-1:0] : (sum[ACC_W] ? LANE_MIN : LANE_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
         sat   <= 1'b0;
      end else if (clr) begin
         value <= '0;
         sat   <= 1'b0;
      end else if (zero) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (add) begin
         value <= sum_sat;
         if (ovf) sat <= 1'b1;
      end
   end

endmodule

// File: rtl/acc_array.sv
// rtl/acc_array.sv - NUM_CH parallel saturating accumulators with serial raw/requantized drain
module acc_array
   import acc_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 16,
   parameter int ACC_W  = 24,
   parameter int OUT_W  = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       acc_clr,
   input  logic                       acc_vld,
   output logic                       acc_rdy,
   input  logic [NUM_CH-1:0]          acc_mask,
   input  logic [NUM_CH*DATA_W-1:0]   acc_data,
   input  logic                       load_vld,
   input  logic [NUM_CH*ACC_W-1:0]    load_data,
   input  logic                       drain_start,
   input  logic                       drain_clr,
   input  logic                       out_mode,
   input  logic [$clog2(ACC_W)-1:0]   out_shift,
   output logic                       out_vld,
   input  logic                       out_rdy,
   output logic [$clog2(NUM_CH)-1:0]  out_ch,
   output logic                       out_last,
   output logic [ACC_W-1:0]           out_data,
   output logic                       busy,
   output logic [NUM_CH-1:0]          sat_flag
);

   localparam int CH_W = $clog2(NUM_CH);
   localparam int SH_W = $clog2(ACC_W);
   localparam logic [CH_W-1:0]        LAST_CH = CH_W'(NUM_CH - 1);
   localparam logic [63:0]            QMAX64  = pos_bound(OUT_W);
   localparam logic [63:0]            QMIN64  = neg_bound(OUT_W);
   localparam logic signed [ACC_W:0]  Q_MAX   = QMAX64[ACC_W:0];
   localparam logic signed [ACC_W:0]  Q_MIN   = QMIN64[ACC_W:0];
   localparam logic [ACC_W:0]         ONE     = {{ACC_W{1'b0}}, 1'b1};

   state_t            state;
   logic [CH_W-1:0]   ptr;
   logic              dclr;
   logic              mode;
   logic [SH_W-1:0]   shift;
   logic              idle;
   logic              last;
   logic              hs;
   logic [ACC_W-1:0]  lane_val [NUM_CH];

   assign idle = (state == ST_IDLE);
   assign last = (ptr == LAST_CH);
   assign hs   = !idle && out_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         ptr   <= '0;
         dclr  <= 1'b0;
         mode  <= OUT_MODE_RAW;
         shift <= '0;
      end else if (acc_clr) begin
         state <= ST_IDLE;
         ptr   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (drain_start) begin
                  state <= ST_DRAIN;
                  ptr   <= '0;
                  dclr  <= drain_clr;
                  mode  <= out_mode;
                  shift <= out_shift;
               end
            end
            ST_DRAIN: begin
               if (out_rdy) begin
                  ptr <= last ? '0 : ptr + CH_W'(1);
                  if (last) state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
      acc_sat_lane #(
         .DATA_W (DATA_W),
         .ACC_W  (ACC_W)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .clr      (acc_clr),
         .zero     (hs && dclr && (ptr == CH_W'(i))),
         .load     (idle && load_vld),
         .load_val (load_data[i*ACC_W +: ACC_W]),
         .add      (idle && acc_vld && acc_mask[i]),
         .data     (acc_data[i*DATA_W +: DATA_W]),
         .value    (lane_val[i]),
         .sat      (sat_flag[i])
      );
   end

   // Requantizer: round-half-up via bias, arithmetic shift, clamp to OUT_W.
   logic [ACC_W-1:0]         sel;
   logic signed [ACC_W:0]    rnd;
   logic signed [ACC_W:0]    t;
   logic signed [ACC_W:0]    r;
   logic [ACC_W-1:0]         q;

   assign sel = lane_val[ptr];
   assign rnd = (shift == '0) ? '0 : (ONE << (shift - SH_W'(1)));
   assign t   = $signed({sel[ACC_W-1], sel}) + rnd;
   assign r   = t >>> shift;
   assign q   = (r > Q_MAX) ? Q_MAX[ACC_W-1:0] :
                (r < Q_MIN) ? Q_MIN[ACC_W-1:0] : r[ACC_W-1:0];

   assign out_vld  = !idle;
   assign busy     = !idle;
   assign acc_rdy  = idle;
   assign out_ch   = ptr;
   assign out_last = !idle && last;
   assign out_data = idle ? '0 : ((mode == OUT_MODE_Q) ? q : sel);

endmodule

// File: tb/tb_acc_array.sv
// tb/tb_acc_array.sv - directed plus randomized self-checking bench for acc_array
module tb_acc_array;

   localparam int NUM_CH = 4;
   localparam int DATA_W = 16;
   localparam int ACC_W  = 24;
   localparam int OUT_W  = 8;
   localparam int CH_W   = $clog2(NUM_CH);
   localparam int SH_W   = $clog2(ACC_W);
   localparam longint AMAX = (longint'(1) <<< (ACC_W - 1)) - 1;
   localparam longint AMIN = -AMAX - 1;
   localparam longint QMAX = (longint'(1) <<< (OUT_W - 1)) - 1;
   localparam longint QMIN = -QMAX - 1;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic                      acc_clr;
   logic                      acc_vld;
   logic                      acc_rdy;
   logic [NUM_CH-1:0]         acc_mask;
   logic [NUM_CH*DATA_W-1:0]  acc_data;
   logic                      load_vld;
   logic [NUM_CH*ACC_W-1:0]   load_data;
   logic                      drain_start;
   logic                      drain_clr;
   logic                      out_mode;
   logic [SH_W-1:0]           out_shift;
   logic                      out_vld;
   logic                      out_rdy;
   logic [CH_W-1:0]           out_ch;
   logic                      out_last;
   logic [ACC_W-1:0]          out_data;
   logic                      busy;
   logic [NUM_CH-1:0]         sat_flag;

   int total = 0;
   int bad   = 0;
   longint            lane_m [NUM_CH];
   logic [NUM_CH-1:0] sat_m;

   always #5 clk = ~clk;

   acc_array #(
      .NUM_CH (NUM_CH),
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .OUT_W  (OUT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .acc_clr     (acc_clr),
      .acc_vld     (acc_vld),
      .acc_rdy     (acc_rdy),
      .acc_mask    (acc_mask),
      .acc_data    (acc_data),
      .load_vld    (load_vld),
      .load_data   (load_data),
      .drain_start (drain_start),
      .drain_clr   (drain_clr),
      .out_mode    (out_mode),
      .out_shift   (out_shift),
      .out_vld     (out_vld),
      .out_rdy     (out_rdy),
      .out_ch      (out_ch),
      .out_last    (out_last),
      .out_data    (out_data),
      .busy        (busy),
      .sat_flag    (sat_flag)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic longint sx(input logic [63:0] v, input int w);
      longint r;
      r = $signed(v << (64 - w));
      return r >>> (64 - w);
   endfunction

   function automatic logic [63:0] bits(input longint v, input int w);
      logic [63:0] m;
      m = (64'd1 << w) - 64'd1;
      return 64'(v) & m;
   endfunction

   function automatic longint req(input longint v, input int s);
      longint t;
      t = v + ((s > 0) ? (longint'(1) <<< (s - 1)) : longint'(0));
      t = t >>> s;
      if (t > QMAX) t = QMAX;
      else if (t < QMIN) t = QMIN;
      return t;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      acc_clr = 0; acc_vld = 0; acc_mask = '0; acc_data = '0;
      load_vld = 0; load_data = '0; drain_start = 0; drain_clr = 0;
      out_mode = 0; out_shift = '0; out_rdy = 0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) lane_m[i] = 0;
      sat_m = '0;
   endtask

   task automatic model_load(input logic [NUM_CH*ACC_W-1:0] v);
      for (int i = 0; i < NUM_CH; i++) lane_m[i] = sx(64'(v[i*ACC_W +: ACC_W]), ACC_W);
   endtask

   task automatic model_acc(input logic [NUM_CH-1:0] mask, input logic [NUM_CH*DATA_W-1:0] d);
      longint s;
      for (int i = 0; i < NUM_CH; i++) begin
         if (mask[i]) begin
            s = lane_m[i] + sx(64'(d[i*DATA_W +: DATA_W]), DATA_W);
            if (s > AMAX) begin s = AMAX; sat_m[i] = 1'b1; end
            else if (s < AMIN) begin s = AMIN; sat_m[i] = 1'b1; end
            lane_m[i] = s;
         end
      end
   endtask

   task automatic do_load(input logic [NUM_CH*ACC_W-1:0] v);
      load_vld = 1; load_data = v;
      tick();
      load_vld = 0;
      model_load(v);
   endtask

   task automatic do_acc(input logic [NUM_CH-1:0] mask, input logic [NUM_CH*DATA_W-1:0] d);
      acc_vld = 1; acc_mask = mask; acc_data = d;
      tick();
      acc_vld = 0;
      model_acc(mask, d);
   endtask

   task automatic do_clr();
      acc_clr = 1;
      tick();
      acc_clr = 0;
      model_reset();
   endtask

   // Full drain; junk acc/load/start beats are driven every drain cycle and must be ignored.
   task automatic drain(input logic mode, input int sh, input logic dclr, input int st0, input bit rstall);
      longint      expv;
      logic [63:0] expb;
      int          stalls;
      out_mode = mode; out_shift = SH_W'(sh); drain_clr = dclr; drain_start = 1; out_rdy = 1;
      tick();
      drain_start = 0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         expv   = mode ? req(lane_m[ch], sh) : lane_m[ch];
         expb   = bits(expv, ACC_W);
         stalls = (ch == 0) ? st0 : (rstall ? int'($urandom_range(0, 1)) : 0);
         for (int k = 0; k <= stalls; k++) begin
            out_rdy     = (k == stalls);
            acc_vld     = 1; acc_mask = '1; acc_data = {$urandom, $urandom};
            load_vld    = 1; load_data = {$urandom, $urandom, $urandom};
            drain_start = 1;
            check("drain_vld", out_vld, 1);
            check("drain_busy", busy, 1);
            check("drain_acc_rdy", acc_rdy, 0);
            check("drain_ch", out_ch, ch);
            check("drain_last", out_last, (ch == NUM_CH - 1));
            check("drain_data", out_data, expb);
            tick();
         end
         if (dclr) lane_m[ch] = 0;
      end
      quiet();
      check("drain_end_busy", busy, 0);
      check("drain_end_acc_rdy", acc_rdy, 1);
      check("drain_end_vld", out_vld, 0);
      check("drain_end_sat", sat_flag, sat_m);
   endtask

   task automatic readback();
      drain(1'b0, 0, 1'b0, 0, 1'b0);
   endtask

   initial begin
      logic [NUM_CH*ACC_W-1:0]  lv;
      logic [NUM_CH*DATA_W-1:0] dv;
      int op;
      rst_n = 0;
      quiet();
      model_reset();
      tick();
      tick();
      check("rst_acc_rdy", acc_rdy, 1);
      check("rst_out_vld", out_vld, 0);
      check("rst_busy", busy, 0);
      check("rst_sat", sat_flag, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_ch", out_ch, 0);
      check("rst_out_last", out_last, 0);
      rst_n = 1;
      tick();

      // Positive and negative lane saturation.
      do_load({24'd0, 24'd0, 24'h800005, 24'h7FFFF0});
      do_acc(4'b0001, {16'd0, 16'd0, 16'd0, 16'h0020});
      check("sat_pos_flag", sat_flag, 4'b0001);
      do_acc(4'b0010, {16'd0, 16'd0, 16'hFFF0, 16'd0});
      check("sat_neg_flag", sat_flag, 4'b0011);
      readback();
      do_load({24'd1, 24'd2, 24'd3, 24'd4});
      check("load_keeps_sat", sat_flag, 4'b0011);
      readback();

      // Requantize, then backpressure, then draining with clear.
      do_load({24'd0, 24'd4096, 24'hFFFFE8, 24'd296});
      drain(1'b1, 4, 1'b0, 0, 1'b0);
      drain(1'b0, 0, 1'b0, 3, 1'b0);
      readback();
      drain(1'b1, 2, 1'b1, 0, 1'b0);
      readback();

      // acc_clr after the ch1 handshake aborts the drain.
      do_load({24'd40, 24'd30, 24'd20, 24'd10});
      out_mode = 0; drain_clr = 0; drain_start = 1; out_rdy = 1;
      tick();
      drain_start = 0;
      check("abort_ch0", out_ch, 0);
      tick();
      check("abort_ch1_data", out_data, 20);
      tick();
      out_rdy = 0; acc_clr = 1;
      tick();
      quiet();
      model_reset();
      check("abort_vld", out_vld, 0);
      check("abort_busy", busy, 0);
      check("abort_acc_rdy", acc_rdy, 1);
      check("abort_sat", sat_flag, 0);
      readback();

      // Priority: clear over accumulate, load over accumulate, per-lane mask.
      do_load({24'd5, 24'd5, 24'd5, 24'd5});
      acc_clr = 1; acc_vld = 1; acc_mask = '1; acc_data = {16'd3, 16'd3, 16'd3, 16'd3};
      tick();
      quiet();
      model_reset();
      readback();
      lv = {24'd77, 24'hFFFF00, 24'd12345, 24'd9};
      load_vld = 1; load_data = lv; acc_vld = 1; acc_mask = '1; acc_data = {16'd1, 16'd1, 16'd1, 16'd1};
      tick();
      quiet();
      model_load(lv);
      readback();
      do_acc(4'b0101, {16'd100, 16'd200, 16'd300, 16'd400});
      readback();

      // Randomized mix against the model.
      for (int it = 0; it < 160; it++) begin
         op = int'($urandom_range(0, 9));
         if (op <= 3 || (op == 6 && $urandom_range(0, 3) != 0)) begin
            dv = {$urandom, $urandom};
            do_acc(NUM_CH'($urandom), dv);
         end else if (op <= 5) begin
            for (int i = 0; i < NUM_CH; i++) begin
               case ($urandom_range(0, 2))
                  0: lv[i*ACC_W +: ACC_W] = ACC_W'($urandom);
                  1: lv[i*ACC_W +: ACC_W] = ACC_W'(AMAX - longint'($urandom_range(0, 40000)));
                  default: lv[i*ACC_W +: ACC_W] = ACC_W'(AMIN + longint'($urandom_range(0, 40000)));
               endcase
            end
            do_load(lv);
         end else if (op == 6) begin
            do_clr();
         end else begin
            drain(1'($urandom), int'($urandom_range(0, ACC_W - 1)),
                  ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)), 1'b1);
         end
         check("rand_sat", sat_flag, sat_m);
      end
      readback();

      // Asynchronous reset in the middle of a drain.
      do_load({24'd1000, 24'd2000, 24'd3000, 24'd4000});
      do_acc(4'b1000, {16'd0, 16'd0, 16'd0, 16'd0});
      do_load({24'h7FFFFF, 24'd1, 24'd2, 24'd3});
      do_acc(4'b1000, {16'd5, 16'd0, 16'd0, 16'd0});
      out_mode = 0; drain_clr = 0; drain_start = 1; out_rdy = 1;
      tick();
      drain_start = 0;
      tick();
      tick();
      tick();
      out_rdy = 0; acc_vld = 1; acc_mask = '1; acc_data = {$urandom, $urandom};
      check("pre_rst_last", out_last, 1);
      #2;
      rst_n = 0;
      #1;
      check("arst_out_vld", out_vld, 0);
      check("arst_busy", busy, 0);
      check("arst_acc_rdy", acc_rdy, 1);
      check("arst_out_ch", out_ch, 0);
      check("arst_out_last", out_last, 0);
      check("arst_out_data", out_data, 0);
      check("arst_sat", sat_flag, 0);
      quiet();
      model_reset();
      tick();
      rst_n = 1;
      tick();
      readback();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/acc_array.md
# acc_array

Multi-lane successor to the single-lane int16 accumulator. It holds NUM_CH independent signed ACC_W-bit saturating accumulators, updated in parallel from a DATA_W-per-lane input beat. Results are read out serially through a valid/ready drain port, one lane per accepted beat, either raw or requantized to OUT_W by a rounding right shift with saturation. The block sits behind the MAC array and feeds the writeback/activation stage.

## Interface
- NUM_CH, 4, number of accumulator lanes (≥2)
- DATA_W, 16, signed input width per lane
- ACC_W, 24, signed accumulator width per lane (≥ DATA_W)
- OUT_W, 8, requantized output width (≤ ACC_W)
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- acc_clr  in  1  synchronous clear of all lanes and sat_flag; aborts a drain
- acc_vld  in  1  accumulate beat valid
- acc_rdy  out  1  accumulate beat accepted; 1 only in IDLE
- acc_mask  in  NUM_CH  per-lane enable for the current acc beat
- acc_data  in  NUM_CH*DATA_W  lane i at [i*DATA_W +: DATA_W]
- load_vld  in  1  overwrite all lanes; honoured in IDLE only
- load_data  in  NUM_CH*ACC_W  lane i at [i*ACC_W +: ACC_W]
- drain_start  in  1  start serial readout; honoured in IDLE only
- drain_clr  in  1  sampled with drain_start: zero each lane once it is read
- out_mode  in  1  sampled with drain_start: 0 raw ACC_W, 1 requantized OUT_W
- out_shift  in  clog2(ACC_W)  sampled with drain_start: right-shift amount
- out_vld  out  1  drain beat valid
- out_rdy  in  1  drain beat accepted
- out_ch  out  clog2(NUM_CH)  lane index of current beat
- out_last  out  1  current beat is lane NUM_CH-1
- out_data  out  ACC_W  lane result; sign-extended to ACC_W in mode 1
- busy  out  1  state is DRAIN
- sat_flag  out  NUM_CH  sticky per-lane saturation seen

## Operation
- States: IDLE, DRAIN. Encodings live in the shared package.
- Lane priority in IDLE: acc_clr > load_vld > (acc_vld & acc_mask[i]). Otherwise the lane holds.
- Accumulate: sum = lane + sext(acc_data_i). On positive overflow the lane takes 2^(ACC_W-1)-1. On negative overflow it takes -2^(ACC_W-1). Either case sets sat_flag[i] (sticky).
- load_vld does not change sat_flag. acc_clr zeroes it.
- IDLE→DRAIN when drain_start & ~acc_clr. This latches drain_clr, out_mode and out_shift, and sets ptr=0.
- In DRAIN: out_vld=1, out_ch=ptr, out_data is a function of lane[ptr] and the latched mode/shift only.
- On out_vld & out_rdy: if drain_clr is latched, lane[ptr]←0. Then ptr++. If ptr was NUM_CH-1, go to IDLE.
- acc_vld, load_vld and drain_start are ignored in DRAIN; acc_rdy=0.
- acc_clr in DRAIN: all lanes and sat_flag clear, go to IDLE next cycle, and out_vld drops even without a handshake (the only permitted valid drop).
- Mode 0: out_data = lane[ptr].
- Mode 1, shift s: t = lane + (s>0 ? 2^(s-1) : 0), evaluated in ACC_W+1 bits; r = t >>> s. Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1], then sign-extend to ACC_W.

## Timing
- Reset: all lanes 0, sat_flag 0, state IDLE, ptr 0, out_vld 0, out_ch 0, out_last 0, out_data 0, busy 0, acc_rdy 1.
- Accumulate, load and clear take effect at the next edge. The new value is visible on the following cycle.
- drain_start at edge k: out_vld=1, out_ch=0 from cycle k+1.
- With out_rdy held high, a drain takes exactly NUM_CH cycles, and acc_rdy returns 1 the cycle after the last accepted beat.
- Under out_rdy=0, out_ch, out_data and out_last stay stable.
- No combinational path from acc_*/load_* to out_*. The only input-to-output combinational path is out_rdy→none.

## Structure
- Shared package acc_pkg: state encodings, OUT_MODE_RAW/OUT_MODE_Q constants, and the lane-saturation and requant-saturation bound functions.
- Sub-module acc_sat_lane (one per lane, generate loop): register with clear/load/enable, saturating adder and sticky flag.
- All registers use DFFRE.
- The requantizer is a single instance on the muxed lane.

## Test plan
- Reset mid-accumulation: assert rst_n low between clock edges → every output takes its reset value immediately.
- Load lane0 0x7FFFF0, acc 0x0020 → lane0 0x7FFFFF, sat_flag=4'b0001. Load lane1 0x800005, acc 0xFFF0 → lane1 0x800000, sat_flag[1]=1.
- Lanes {296, -24, 4096, 0}, drain mode 1, shift 4, out_rdy=1 → out_data 0x000013, 0xFFFFFF, 0x00007F, 0x000000 over 4 cycles; out_last on ch 3.
- Backpressure: out_rdy=0 for 3 cycles at ch 0 → out_ch/out_data stable, acc_rdy=0, acc_vld beats not absorbed; busy falls one cycle after the ch 3 handshake.
- drain_clr=1 full drain → all lanes 0 afterwards.
- acc_clr after the ch 1 handshake → IDLE next cycle, out_vld 0, all lanes 0.
- acc_clr and acc_vld together with lane value 5, data 3 → lane 0; load_vld and acc_vld together → lane takes load_data; acc_mask=4'b0101 → only lanes 0 and 2 change.
